// File: rtl/ppu_render_seq_pkg.sv
// Shared definitions for the PPU render sequencer: fetch-slot encodings,
// scanline dot boundaries and the per-group slot lookups.
package ppu_render_seq_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_NT    = 3'd1,
    FETCH_AT    = 3'd2,
    FETCH_BG_LO = 3'd3,
    FETCH_BG_HI = 3'd4,
    FETCH_GNT   = 3'd5,
    FETCH_SP_LO = 3'd6,
    FETCH_SP_HI = 3'd7
  } fetch_slot_t;

  // Dot boundaries within a scanline
  localparam logic [8:0] DOT_BG_END   = 9'd256;  // last background fetch dot
  localparam logic [8:0] DOT_SP_START = 9'd257;  // first sprite fetch dot, t->v horizontal copy
  localparam logic [8:0] DOT_CV_START = 9'd280;  // first t->v vertical copy dot
  localparam logic [8:0] DOT_CV_END   = 9'd304;  // last t->v vertical copy dot
  localparam logic [8:0] DOT_SP_END   = 9'd320;  // last sprite fetch dot
  localparam logic [8:0] DOT_PF_END   = 9'd336;  // last prefetch dot for the next line
  localparam logic [8:0] DOT_LINE_END = 9'd340;  // last dot of a full-length line

  // Background fetch slot for g = dot % 8; each fetch spans two dots
  function automatic fetch_slot_t slot_bg(input logic [2:0] g);
    fetch_slot_t s;
    case (g)
      3'd1, 3'd2: s = FETCH_NT;
      3'd3, 3'd4: s = FETCH_AT;
      3'd5, 3'd6: s = FETCH_BG_LO;
      default:    s = FETCH_BG_HI;
    endcase
    return s;
  endfunction

  // Sprite fetch slot for g = dot % 8; the first two fetches are garbage NT reads
  function automatic fetch_slot_t slot_sp(input logic [2:0] g);
    fetch_slot_t s;
    case (g)
      3'd1, 3'd2, 3'd3, 3'd4: s = FETCH_GNT;
      3'd5, 3'd6:             s = FETCH_SP_LO;
      default:                s = FETCH_SP_HI;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ppu_dot_timer.sv
// Dot/line timebase: clock prescaler, dot and line counters, frame parity
// and the odd-frame short pre-render line.
module ppu_dot_timer #(
  parameter int CLK_PER_DOT     = 4,
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int ODD_SKIP        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       render_en,
  output logic       dot_tick,
  output logic       dot_first,
  output logic [8:0] dot,
  output logic [8:0] line,
  output logic       odd_frame
);

  localparam int PW = $clog2(CLK_PER_DOT);
  localparam logic [PW-1:0] PS_LAST  = PW'(CLK_PER_DOT - 1);
  localparam logic [PW-1:0] PS_ONE   = PW'(1);
  localparam logic [8:0]    DOT_LAST = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0]    DOT_SKIP = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0]    LINE_PRE = 9'(LINES_PER_FRAME - 1);

  logic [PW-1:0] prescaler;
  logic          skip_now;

  // Odd frames with rendering on jump from the second-to-last pre-line dot straight to line 0
  assign skip_now = (ODD_SKIP != 0) && odd_frame && render_en &&
                    (line == LINE_PRE) && (dot == DOT_SKIP);

  // dot_tick/dot_first are kept as flops that mirror the prescaler's last/first count
  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaler <= '0;
      dot_tick  <= 1'b0;
      dot_first <= 1'b1;
      dot       <= '0;
      line      <= LINE_PRE;
      odd_frame <= 1'b0;
    end else if (dot_tick) begin
      prescaler <= '0;
      dot_tick  <= 1'b0;
      dot_first <= 1'b1;
      if (skip_now) begin
        dot       <= '0;
        line      <= '0;
        odd_frame <= ~odd_frame;
      end else if (dot == DOT_LAST) begin
        dot <= '0;
        if (line == LINE_PRE) begin
          line      <= '0;
          odd_frame <= ~odd_frame;
        end else begin
          line <= line + 9'd1;
        end
      end else begin
        dot <= dot + 9'd1;
      end
    end else begin
      prescaler <= prescaler + PS_ONE;
      dot_tick  <= ((prescaler + PS_ONE) == PS_LAST);
      dot_first <= 1'b0;
    end
  end

endmodule

// File: rtl/ppu_render_seq.sv
// PPU render timing and fetch-slot sequencer. Decodes the per-dot fetch slot
// and scroll/shifter strobes from the dot timer and owns vblank/NMI.
// Slot and strobe outputs are decoded only from flops (dot, line, dot_first,
// render_q) so they change in the same clk as dot/line, with no extra latency.
module ppu_render_seq
  import ppu_render_seq_pkg::*;
#(
  parameter int CLK_PER_DOT     = 4,
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VISIBLE_LINES   = 240,
  parameter int VBLANK_LINE     = 241,
  parameter int ODD_SKIP        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       render_en,
  input  logic       nmi_en,
  input  logic       vblank_clr,
  output logic       dot_tick,
  output logic [8:0] dot,
  output logic [8:0] line,
  output logic [2:0] fetch_slot,
  output logic       fetch_req,
  output logic       shift_load,
  output logic       inc_hori,
  output logic       inc_vert,
  output logic       copy_hori,
  output logic       copy_vert,
  output logic       visible,
  output logic       vblank,
  output logic       nmi,
  output logic       odd_frame
);

  localparam logic [8:0] LINE_PRE = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] LINE_VIS = 9'(VISIBLE_LINES);
  localparam logic [8:0] LINE_VBL = 9'(VBLANK_LINE);

  logic        dot_first;
  logic        render_q;
  logic        active;
  logic [2:0]  g;
  fetch_slot_t slot;
  logic        vblank_next;

  ppu_dot_timer #(
    .CLK_PER_DOT    (CLK_PER_DOT),
    .DOTS_PER_LINE  (DOTS_PER_LINE),
    .LINES_PER_FRAME(LINES_PER_FRAME),
    .ODD_SKIP       (ODD_SKIP)
  ) u_dot_timer (
    .clk      (clk),
    .rst      (rst),
    .render_en(render_en),
    .dot_tick (dot_tick),
    .dot_first(dot_first),
    .dot      (dot),
    .line     (line),
    .odd_frame(odd_frame)
  );

  assign g       = dot[2:0];
  assign active  = render_q && ((line < LINE_VIS) || (line == LINE_PRE));
  assign visible = (line < LINE_VIS) && (dot >= 9'd1) && (dot <= DOT_BG_END);
  assign fetch_slot = slot;

  // Fetch slot per dot, single-clk strobes on the first clk of the dot, vertical copy as a level
  always_comb begin
    slot       = FETCH_IDLE;
    fetch_req  = 1'b0;
    shift_load = 1'b0;
    inc_hori   = 1'b0;
    inc_vert   = 1'b0;
    copy_hori  = 1'b0;
    copy_vert  = 1'b0;
    if (active) begin
      if (((dot >= 9'd1) && (dot <= DOT_BG_END)) ||
          ((dot > DOT_SP_END) && (dot <= DOT_PF_END))) begin
        slot = slot_bg(g);
      end else if ((dot >= DOT_SP_START) && (dot <= DOT_SP_END)) begin
        slot = slot_sp(g);
      end else if (dot > DOT_PF_END) begin
        slot = FETCH_NT;
      end
      if (dot_first) begin
        fetch_req  = dot[0] && (dot < DOT_LINE_END);
        shift_load = ((g == 3'd1) && (dot >= 9'd9) && (dot <= DOT_SP_START)) ||
                     (dot == DOT_SP_END + 9'd9) || (dot == DOT_PF_END + 9'd1);
        inc_hori   = ((g == 3'd0) && (dot != 9'd0) && (dot <= DOT_BG_END)) ||
                     (dot == DOT_SP_END + 9'd8) || (dot == DOT_PF_END);
        inc_vert   = (dot == DOT_BG_END);
        copy_hori  = (dot == DOT_SP_START);
      end
      copy_vert = (line == LINE_PRE) && (dot >= DOT_CV_START) && (dot <= DOT_CV_END);
    end
  end

  // vblank set/clear at the dot-0 -> dot-1 boundary; a CPU status read overrides a coincident set
  always_comb begin
    vblank_next = vblank;
    if (vblank_clr) begin
      vblank_next = 1'b0;
    end else if (dot_tick && (dot == 9'd0) && (line == LINE_VBL)) begin
      vblank_next = 1'b1;
    end else if (dot_tick && (dot == 9'd0) && (line == LINE_PRE)) begin
      vblank_next = 1'b0;
    end
  end

  // Status/NMI flops and the per-dot sample of render_en
  always_ff @(posedge clk) begin
    if (!rst) begin
      vblank   <= 1'b0;
      nmi      <= 1'b0;
      render_q <= 1'b0;
    end else begin
      vblank <= vblank_next;
      nmi    <= vblank_next & nmi_en;
      if (dot_tick) begin
        render_q <= render_en;
      end
    end
  end

endmodule
